id_hazard_scoreboard: RTL and testbench

Parametrised RAW-hazard and forwarding unit for the decode stage. It sits beside the ID/EX pipeline registers and replaces the fixed three-comparator hazard detector. It keeps a shadow shift register of the destination registers in flight across DEPTH downstream stages. From that record it drives PC/IF-ID enables, bubble insertion into ID/EX, per-operand forwarding selects and a stall-cycle counter. Stage count, forwarding mode and register-file bypass are all parameters.

---
 rtl/id_hazard_scoreboard_pkg.sv | 17 +
 rtl/id_hazard_scoreboard_hazard_match.sv | 39 +++
 rtl/id_hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared types and helpers for the ID-stage hazard scoreboard
package id_hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } sb_entry_t;

  // Select 0 means register file; k means entry k-1, so DEPTH+1 codes are needed.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_hazard_match.sv
// rtl/id_hazard_scoreboard_hazard_match.sv - one source operand against every in-flight destination
module hazard_match
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic [DEPTH-1:0]                 entry_v,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd,
  input  logic                             id_valid,
  input  logic                             use_rs,
  input  logic [REG_ADDR_W-1:0]            rs,
  output logic [DEPTH-1:0]                 match,
  output logic [fwd_sel_w(DEPTH)-1:0]      youngest
);

  localparam int SEL_W = fwd_sel_w(DEPTH);

  // A write-through register file already supplies the oldest entry's value.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = use_rs & id_valid & entry_v[k] & (entry_rd[k] == rs);
      if (RF_BYPASS && (k == DEPTH - 1)) begin
        match[k] = 1'b0;
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    youngest = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        youngest = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - RAW hazard detection, stall control and forwarding selects for ID
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rs1,
  input  logic [REG_ADDR_W-1:0]         id_rs2,
  input  logic                          id_use_rs1,
  input  logic                          id_use_rs2,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_wr,
  input  logic                          id_is_load,
  input  logic                          id_flush,
  input  logic                          pipe_hold,
  output logic                          stall,
  output logic                          en_pc,
  output logic                          en_if_id,
  output logic                          id_ex_en,
  output logic                          bubble,
  output logic [fwd_sel_w(DEPTH)-1:0]   fwd_sel_rs1,
  output logic [fwd_sel_w(DEPTH)-1:0]   fwd_sel_rs2,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int SEL_W = fwd_sel_w(DEPTH);

  sb_entry_t [DEPTH-1:0]            entries;
  logic [DEPTH-1:0]                 entry_v;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
  logic [DEPTH-1:0]                 match_rs1;
  logic [DEPTH-1:0]                 match_rs2;
  logic [SEL_W-1:0]                 young_rs1;
  logic [SEL_W-1:0]                 young_rs2;
  logic                             raw_hazard;
  logic                             push;
  sb_entry_t                        new_entry;
  logic                             unused_tail_ld;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entry_v[k]  = entries[k].v;
      entry_rd[k] = entries[k].rd;
    end
  end

  // The oldest entry's load flag is shifted out without ever being consulted.
  assign unused_tail_ld = entries[DEPTH-1].ld;

  hazard_match #(
    .DEPTH     (DEPTH),
    .RF_BYPASS (RF_BYPASS)
  ) u_match_rs1 (
    .entry_v  (entry_v),
    .entry_rd (entry_rd),
    .id_valid (id_valid),
    .use_rs   (id_use_rs1),
    .rs       (id_rs1),
    .match    (match_rs1),
    .youngest (young_rs1)
  );

  hazard_match #(
    .DEPTH     (DEPTH),
    .RF_BYPASS (RF_BYPASS)
  ) u_match_rs2 (
    .entry_v  (entry_v),
    .entry_rd (entry_rd),
    .id_valid (id_valid),
    .use_rs   (id_use_rs2),
    .rs       (id_rs2),
    .match    (match_rs2),
    .youngest (young_rs2)
  );

  // With forwarding, only a load directly ahead cannot be bypassed in time.
  always_comb begin
    if (FWD_EN) begin
      raw_hazard = entries[0].ld & (match_rs1[0] | match_rs2[0]);
    end else begin
      raw_hazard = |{match_rs1, match_rs2};
    end
  end

  assign stall       = raw_hazard & ~id_flush;
  assign en_pc       = ~stall & ~pipe_hold;
  assign en_if_id    = ~stall & ~pipe_hold;
  assign id_ex_en    = ~pipe_hold;
  assign bubble      = ~pipe_hold & (stall | id_flush | ~id_valid);
  assign fwd_sel_rs1 = (FWD_EN && !stall) ? young_rs1 : '0;
  assign fwd_sel_rs2 = (FWD_EN && !stall) ? young_rs2 : '0;

  assign push = id_valid & ~stall & ~id_flush;

  // x0 is never recorded as a destination, so it can never match.
  always_comb begin
    new_entry = '0;
    if (push) begin
      new_entry.v  = id_reg_wr & (id_rd != '0);
      new_entry.rd = id_rd;
      new_entry.ld = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (!pipe_hold) begin
      entries[0] <= new_entry;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !pipe_hold && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       hd;
  } in_t;

  typedef struct packed {
    int          step;
    int          dut;
    logic        stall;
    logic        en_pc;
    logic        id_ex_en;
    logic        bubble;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  in_t         inp [3];
  logic        o_stall [3];
  logic        o_en_pc [3];
  logic        o_en_if_id [3];
  logic        o_id_ex_en [3];
  logic        o_bubble [3];
  logic [1:0]  o_f1 [3];
  logic [1:0]  o_f2 [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  exp_t        sb [$];
  exp_t        me;
  int          checks;
  int          errors;
  int          step_no;
  int          exp_cnt [3];
  in_t         idle;
  in_t         dep;
  in_t         lwx3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(inp[0].v), .id_rs1(inp[0].rs1), .id_rs2(inp[0].rs2),
    .id_use_rs1(inp[0].u1), .id_use_rs2(inp[0].u2), .id_rd(inp[0].rd), .id_reg_wr(inp[0].wr),
    .id_is_load(inp[0].ld), .id_flush(inp[0].fl), .pipe_hold(inp[0].hd), .stall(o_stall[0]),
    .en_pc(o_en_pc[0]), .en_if_id(o_en_if_id[0]), .id_ex_en(o_id_ex_en[0]), .bubble(o_bubble[0]),
    .fwd_sel_rs1(o_f1[0]), .fwd_sel_rs2(o_f2[0]), .stall_cnt(cnt0)
  );

  id_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(inp[1].v), .id_rs1(inp[1].rs1), .id_rs2(inp[1].rs2),
    .id_use_rs1(inp[1].u1), .id_use_rs2(inp[1].u2), .id_rd(inp[1].rd), .id_reg_wr(inp[1].wr),
    .id_is_load(inp[1].ld), .id_flush(inp[1].fl), .pipe_hold(inp[1].hd), .stall(o_stall[1]),
    .en_pc(o_en_pc[1]), .en_if_id(o_en_if_id[1]), .id_ex_en(o_id_ex_en[1]), .bubble(o_bubble[1]),
    .fwd_sel_rs1(o_f1[1]), .fwd_sel_rs2(o_f2[1]), .stall_cnt(cnt1)
  );

  id_hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(inp[2].v), .id_rs1(inp[2].rs1), .id_rs2(inp[2].rs2),
    .id_use_rs1(inp[2].u1), .id_use_rs2(inp[2].u2), .id_rd(inp[2].rd), .id_reg_wr(inp[2].wr),
    .id_is_load(inp[2].ld), .id_flush(inp[2].fl), .pipe_hold(inp[2].hd), .stall(o_stall[2]),
    .en_pc(o_en_pc[2]), .en_if_id(o_en_if_id[2]), .id_ex_en(o_id_ex_en[2]), .bubble(o_bubble[2]),
    .fwd_sel_rs1(o_f1[2]), .fwd_sel_rs2(o_f2[2]), .stall_cnt(cnt2)
  );

  function automatic in_t ins(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic ld, input logic fl, input logic hd);
    in_t x;
    x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd; x.wr = wr; x.ld = ld; x.fl = fl; x.hd = hd;
    return x;
  endfunction

  function automatic logic [15:0] cnt_of(input int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      default: return {12'd0, cnt2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, want);
    end
  endtask

  // One ID cycle on one DUT: drive its inputs, queue the expected outputs, take the edge.
  task automatic step(input int d, input in_t x, input logic es,
                      input logic [1:0] e1, input logic [1:0] e2);
    exp_t e;
    for (int i = 0; i < 3; i++) inp[i] = idle;
    inp[d] = x;
    e.step     = step_no;
    e.dut      = d;
    e.stall    = es;
    e.en_pc    = !es && !x.hd;
    e.id_ex_en = !x.hd;
    e.bubble   = !x.hd && (es || x.fl || !x.v);
    e.f1       = e1;
    e.f2       = e2;
    e.cnt      = exp_cnt[d][15:0];
    sb.push_back(e);
    @(posedge clk);
    if (es && !x.hd && rst_n && exp_cnt[d] < ((d == 2) ? 15 : 65535)) exp_cnt[d]++;
    step_no++;
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      me = sb.pop_front();
      chk($sformatf("s%0d.d%0d.stall", me.step, me.dut), 32'(o_stall[me.dut]), 32'(me.stall));
      chk($sformatf("s%0d.d%0d.en_pc", me.step, me.dut), 32'(o_en_pc[me.dut]), 32'(me.en_pc));
      chk($sformatf("s%0d.d%0d.en_if_id", me.step, me.dut), 32'(o_en_if_id[me.dut]), 32'(me.en_pc));
      chk($sformatf("s%0d.d%0d.id_ex_en", me.step, me.dut), 32'(o_id_ex_en[me.dut]), 32'(me.id_ex_en));
      chk($sformatf("s%0d.d%0d.bubble", me.step, me.dut), 32'(o_bubble[me.dut]), 32'(me.bubble));
      chk($sformatf("s%0d.d%0d.fwd1", me.step, me.dut), 32'(o_f1[me.dut]), 32'(me.f1));
      chk($sformatf("s%0d.d%0d.fwd2", me.step, me.dut), 32'(o_f2[me.dut]), 32'(me.f2));
      chk($sformatf("s%0d.d%0d.cnt", me.step, me.dut), 32'(cnt_of(me.dut)), 32'(me.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    idle  = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dep   = ins(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    lwx3  = ins(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) inp[i] = idle;
    @(posedge clk);
    #1;

    // reset state
    step(0, idle, 0, 0, 0);
    step(1, idle, 0, 0, 0);
    step(2, idle, 0, 0, 0);
    rst_n = 1'b1;

    // load-use with forwarding: one stall, then forward from entry 1
    step(0, ins(1, 0, 0, 0, 0, 5, 1, 1, 0, 0), 0, 0, 0);
    step(0, ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0), 1, 0, 0);
    step(0, ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0), 0, 2, 0);

    // ALU chains: youngest producer wins, entry 2 is covered by the register file
    step(0, ins(1, 6, 1, 0, 1, 5, 1, 0, 0, 0), 0, 1, 0);
    step(0, ins(1, 5, 1, 0, 1, 5, 1, 0, 0, 0), 0, 1, 0);
    step(0, ins(1, 5, 1, 5, 1, 7, 1, 0, 0, 0), 0, 1, 1);
    step(0, ins(1, 5, 1, 7, 1, 8, 1, 0, 0, 0), 0, 2, 1);
    step(0, ins(1, 5, 1, 0, 0, 9, 1, 0, 0, 0), 0, 0, 0);

    // a load to x0 is never a hazard
    step(0, ins(1, 0, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, 0);
    step(0, ins(1, 0, 1, 0, 1, 10, 1, 0, 0, 0), 0, 0, 0);

    // load-use under pipe_hold: frozen, uncounted, then exactly one stall
    step(0, lwx3, 0, 0, 0);
    repeat (3) step(0, ins(1, 3, 1, 0, 0, 4, 1, 0, 0, 1), 1, 0, 0);
    step(0, dep, 1, 0, 0);
    step(0, dep, 0, 2, 0);

    // flush over a hazard: no stall, bubble, entry 0 left invalid
    step(0, lwx3, 0, 0, 0);
    step(0, ins(1, 3, 1, 0, 0, 4, 1, 0, 1, 0), 0, 1, 0);
    step(0, ins(1, 4, 1, 0, 0, 11, 1, 0, 0, 0), 0, 0, 0);

    // no forwarding: back-to-back dependency stalls two cycles
    step(1, ins(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), 0, 0, 0);
    step(1, ins(1, 5, 1, 5, 1, 7, 1, 0, 0, 0), 1, 0, 0);
    step(1, ins(1, 5, 1, 5, 1, 7, 1, 0, 0, 0), 1, 0, 0);
    step(1, ins(1, 5, 1, 5, 1, 7, 1, 0, 0, 0), 0, 0, 0);
    step(1, ins(1, 7, 1, 0, 0, 8, 1, 0, 1, 0), 0, 0, 0);
    step(1, ins(1, 7, 1, 0, 0, 8, 1, 0, 0, 0), 1, 0, 0);
    step(1, ins(1, 7, 1, 0, 0, 8, 1, 0, 0, 0), 0, 0, 0);

    // 4-bit counter: 21 load-use stalls saturate at 15
    step(2, lwx3, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      step(2, ins(1, 3, 1, 0, 0, 3, 1, 1, 0, 0), 1, 0, 0);
      step(2, ins(1, 3, 1, 0, 0, 3, 1, 1, 0, 0), 0, 2, 0);
    end
    step(2, idle, 0, 0, 0);

    // reset asserted while a load-use hazard is in ID
    step(0, lwx3, 0, 0, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    step(0, dep, 0, 0, 0);
    step(2, dep, 0, 0, 0);
    rst_n = 1'b1;
    step(0, dep, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
